// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared types and helpers for the fifo_flex buffering primitive.
//   CNT_W(depth)   - width of an occupancy counter able to hold 0..depth
//   fifo_status_t  - bundle of the four status flags for instantiating blocks
//   DEF_WIDTH/DEF_DEPTH - default geometry
package fifo_flex_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flex_mem.sv
// fifo_flex_mem: DEPTH x WIDTH storage for fifo_flex.
//   Synchronous write port (we/waddr/wdata) and an address-in read port.
//   Default build: rdata is registered, loaded from mem[raddr] when re is high,
//   cleared by rst, held otherwise.
//   FIFO_FLEX_FWFT_EN defined: rdata = mem[raddr] combinationally.
// Ports: clk, rst (async, active-high), we, waddr, wdata, re, raddr, rdata.
module fifo_flex_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Storage is deliberately not reset; the pointers define what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FLEX_FWFT_EN
  assign rdata = mem[raddr];

  // Read enable and reset only matter for the registered read port.
  logic unused_rd;
  assign unused_rd = re | rst;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow flags.
//   Build option: FIFO_FLEX_FWFT_EN selects first-word-fall-through read data;
//   otherwise read_data is registered one cycle after an accepted pop.
// Ports:
//   clk, rst (async, active-high)
//   push, write_data       - write side; push into full accepted only with a pop
//   pop, read_data         - read side
//   fifo_full, fifo_empty, almost_full, almost_empty, count - status from count
//   err_clr, overflow, underflow - sticky rejected-operation flags
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         read_data,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = CNT_W(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_flex: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_flex: AF_LEVEL=%0d outside 1..DEPTH", AF_LEVEL);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flex: AE_LEVEL=%0d outside 0..DEPTH-1", AE_LEVEL);
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  fifo_status_t     st;
  logic             pop_ok, push_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Flags come straight off the registered count: post-edge, no extra latency.
  always_comb begin
    st.full         = (cnt == FULL_CNT);
    st.empty        = (cnt == '0);
    st.almost_full  = (cnt >= AF_CNT);
    st.almost_empty = (cnt <= AE_CNT);
  end

  // A pop frees the slot a same-cycle push needs, so full+pop admits the push.
  assign pop_ok  = pop && !st.empty;
  assign push_ok = push && (!st.full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky errors: a new rejection wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (pop && st.empty)  underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

  fifo_flex_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (write_data),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FLEX_FWFT_EN
  // Head word is presented whenever valid; zero when nothing is stored.
  assign read_data = st.empty ? '0 : mem_rdata;
`else
  assign read_data = mem_rdata;
`endif

  assign count        = cnt;
  assign fifo_full    = st.full;
  assign fifo_empty   = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed + randomized checks of fifo_flex (WIDTH=8, DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2) against a queue-based reference model.
module tb_fifo_flex;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic [WIDTH-1:0] read_data;
  logic             fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0]       count;
  logic             overflow, underflow;

  fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .write_data   (write_data),
    .pop          (pop),
    .read_data    (read_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rd;
  bit               m_ovf, m_unf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_rd();
`ifdef FIFO_FLEX_FWFT_EN
    return (q.size() > 0) ? q[0] : '0;
`else
    return m_rd;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".read_data"}, 32'(read_data), 32'(exp_rd()));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock cycle: drive at negedge, apply the FIFO rules at posedge, check after.
  task automatic step(input string tag, input bit p, input logic [WIDTH-1:0] d,
                      input bit o, input bit c);
    bit pop_ok, push_ok, was_empty;
    @(negedge clk);
    push = p; write_data = d; pop = o; err_clr = c;
    @(posedge clk);
    was_empty = (q.size() == 0);
    pop_ok    = o && !was_empty;
    push_ok   = p && (q.size() < DEPTH || pop_ok);
    if (pop_ok)  m_rd = q.pop_front();
    if (push_ok) q.push_back(d);
    if (p && !push_ok)   m_ovf = 1'b1;
    else if (c)          m_ovf = 1'b0;
    if (o && was_empty)  m_unf = 1'b1;
    else if (c)          m_unf = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic push/pop ordering and registered latency
    step("p1", 1, 8'h01, 0, 0);
    step("p2", 1, 8'h02, 0, 0);
    step("p3", 1, 8'h03, 0, 0);
    step("pop1", 0, 8'h00, 1, 0);
    step("pop2", 0, 8'h00, 1, 0);
    step("pop3", 0, 8'h00, 1, 0);

    // Fill across the pointer wrap, overflow, drain
    for (int i = 0; i < 8; i++) step("fill", 1, 8'(8'h10 + i), 0, 0);
    step("ovf", 1, 8'hEE, 0, 0);
    step("hold_full", 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step("drain", 0, 8'h00, 1, 0);

    // Push+pop at full
    for (int i = 0; i < 8; i++) step("refill", 1, 8'(8'h20 + i), 0, 1);
    step("full_pp", 1, 8'hAA, 1, 0);
    for (int i = 0; i < 8; i++) step("drain2", 0, 8'h00, 1, 0);

    // Push+pop at empty, error clear, clear-vs-set priority
    step("empty_pp", 1, 8'h55, 1, 0);
    step("pop55", 0, 8'h00, 1, 0);
    step("clr", 0, 8'h00, 0, 1);
    step("clr_vs_unf", 0, 8'h00, 1, 1);
    step("ovf_setup", 0, 8'h00, 0, 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step("burst", 1, 8'(8'h40 + i), 0, 0);
    step("burst_pop", 0, 8'h00, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    push = 0; pop = 0; err_clr = 0;
    rst = 1'b0;
    step("post_rst_push", 1, 8'h77, 0, 0);
    step("post_rst_pop", 0, 8'h00, 1, 0);

`ifdef FIFO_FLEX_FWFT_EN
    step("fwft_push", 1, 8'h33, 0, 0);
    step("fwft_idle", 0, 8'h00, 0, 0);
    step("fwft_pop", 0, 8'h00, 1, 0);
`endif

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 400; i++) begin
      int  bias;
      bit  p, o, c;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(99) < bias);
      o = ($urandom_range(99) < (100 - bias));
      c = ($urandom_range(99) < 10);
      step("rand", p, 8'($urandom), o, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
